// File: rtl/pong_pkg.sv
// Shared pong definitions: button direction encoding, paddle FSM states,
// screen geometry, and a helper that turns two button levels into a direction.
// No ports (package).
package pong_pkg;

  localparam int SCREEN_H = 480;
  localparam int PADDLE_H = 80;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    UP   = 2'b01,
    DN   = 2'b10
  } dir_e;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT,
    FAST
  } paddle_state_e;

  // Both buttons held (or neither) resolves to NONE.
  function automatic dir_e dir_decode(input logic up, input logic dn);
    if (up && !dn)      return UP;
    else if (dn && !up) return DN;
    else                return NONE;
  endfunction

endpackage

// File: rtl/paddle_clamp_step.sv
// Combinational saturating move of a paddle position by one step.
// Ports:
//   pos_i  [POS_W-1:0]  current position
//   step_i [POS_W-1:0]  step magnitude
//   up_i                1 = move toward POS_MIN, 0 = move toward POS_MAX
//   pos_o  [POS_W-1:0]  moved position, clamped to [POS_MIN, POS_MAX]
module paddle_clamp_step #(
  parameter int POS_W   = 10,
  parameter int POS_MIN = 0,
  parameter int POS_MAX = 400
) (
  input  logic [POS_W-1:0] pos_i,
  input  logic [POS_W-1:0] step_i,
  input  logic             up_i,
  output logic [POS_W-1:0] pos_o
);

  localparam logic [POS_W:0] MIN_X = (POS_W+1)'(POS_MIN);
  localparam logic [POS_W:0] MAX_X = (POS_W+1)'(POS_MAX);

  logic [POS_W:0] pos_x;
  logic [POS_W:0] step_x;
  logic [POS_W:0] sum_x;
  logic [POS_W:0] res_x;

  // One extra bit keeps both the subtract guard and the add free of wrap.
  always_comb begin
    pos_x  = {1'b0, pos_i};
    step_x = {1'b0, step_i};
    sum_x  = pos_x + step_x;
    res_x  = pos_x;
    if (up_i) begin
      if (pos_x < MIN_X + step_x) res_x = MIN_X;
      else                        res_x = pos_x - step_x;
    end else begin
      if (sum_x > MAX_X) res_x = MAX_X;
      else               res_x = sum_x;
    end
    pos_o = POS_W'(res_x);
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: turns debounced up/down levels into a paddle Y.
// A fresh press moves one STEP immediately; holding for HOLD_TICKS ticks starts
// auto-repeat every REPEAT_TICKS ticks, switching to FAST_STEP after
// ACCEL_MOVES repeat moves. Position is clamped to [POS_MIN, POS_MAX].
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   tick             one-clk sample/frame strobe
//   up_db, down_db   debounced button levels (1 = held)
//   game_en          1 = paddle may move
//   recenter         synchronous load of POS_RST
//   pos              registered paddle Y
//   at_top, at_bot   registered pos==POS_MIN / pos==POS_MAX
//   moving           registered, FSM not IDLE
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int POS_W        = 10,
  parameter int POS_MIN      = 0,
  parameter int POS_MAX      = SCREEN_H - PADDLE_H,
  parameter int POS_RST      = 200,
  parameter int STEP         = 4,
  parameter int FAST_STEP    = 8,
  parameter int HOLD_TICKS   = 8,
  parameter int REPEAT_TICKS = 2,
  parameter int ACCEL_MOVES  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             up_db,
  input  logic             down_db,
  input  logic             game_en,
  input  logic             recenter,
  output logic [POS_W-1:0] pos,
  output logic             at_top,
  output logic             at_bot,
  output logic             moving
);

  localparam int TMAX   = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int TCNT_W = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int MCNT_W = $clog2(ACCEL_MOVES + 1);

  localparam logic [TCNT_W-1:0] HOLD_LAST   = TCNT_W'(HOLD_TICKS - 1);
  localparam logic [TCNT_W-1:0] REPEAT_LAST = TCNT_W'(REPEAT_TICKS - 1);
  localparam logic [MCNT_W-1:0] ACCEL_N     = MCNT_W'(ACCEL_MOVES);

  paddle_state_e     state_q, state_d;
  dir_e              dir, prev_dir_q;
  logic [TCNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [MCNT_W-1:0] move_cnt_q, move_cnt_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              at_top_q, at_bot_q, moving_q;

  logic              press;
  logic              do_move;
  logic [POS_W-1:0]  step_sel;
  logic [POS_W-1:0]  moved_pos;

  assign dir   = dir_decode(up_db, down_db);
  assign press = (dir != NONE) && (dir != prev_dir_q);

  paddle_clamp_step #(
    .POS_W   (POS_W),
    .POS_MIN (POS_MIN),
    .POS_MAX (POS_MAX)
  ) u_clamp (
    .pos_i  (pos_q),
    .step_i (step_sel),
    .up_i   (dir == UP),
    .pos_o  (moved_pos)
  );

  // Control: priority recenter > disable > no direction > press edge > FSM.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    move_cnt_d = move_cnt_q;
    do_move    = 1'b0;
    step_sel   = POS_W'(STEP);
    if (recenter || !game_en || dir == NONE) begin
      state_d    = IDLE;
      tick_cnt_d = '0;
      move_cnt_d = '0;
    end else if (press) begin
      do_move    = 1'b1;
      state_d    = DELAY;
      tick_cnt_d = '0;
      move_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        DELAY: begin
          if (tick) begin
            if (tick_cnt_q == HOLD_LAST) begin
              do_move    = 1'b1;
              tick_cnt_d = '0;
              state_d    = REPEAT;
            end else begin
              tick_cnt_d = tick_cnt_q + TCNT_W'(1);
            end
          end
        end
        REPEAT, FAST: begin
          if (state_q == FAST) step_sel = POS_W'(FAST_STEP);
          if (tick) begin
            if (tick_cnt_q == REPEAT_LAST) begin
              do_move    = 1'b1;
              tick_cnt_d = '0;
              if (move_cnt_q != ACCEL_N) move_cnt_d = move_cnt_q + MCNT_W'(1);
              if (move_cnt_d == ACCEL_N) state_d = FAST;
            end else begin
              tick_cnt_d = tick_cnt_q + TCNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pos_d = pos_q;
    if (recenter)     pos_d = POS_W'(POS_RST);
    else if (do_move) pos_d = moved_pos;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_dir_q <= NONE;
      tick_cnt_q <= '0;
      move_cnt_q <= '0;
      pos_q      <= POS_W'(POS_RST);
      at_top_q   <= 1'b0;
      at_bot_q   <= 1'b0;
      moving_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_dir_q <= dir;
      tick_cnt_q <= tick_cnt_d;
      move_cnt_q <= move_cnt_d;
      pos_q      <= pos_d;
      at_top_q   <= (pos_d == POS_W'(POS_MIN));
      at_bot_q   <= (pos_d == POS_W'(POS_MAX));
      moving_q   <= (state_d != IDLE);
    end
  end

  assign pos    = pos_q;
  assign at_top = at_top_q;
  assign at_bot = at_bot_q;
  assign moving = moving_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed self-checking bench for paddle_ctrl. A second instance reset to
// position 2 shares all inputs and exercises the top-edge clamp.
module tb_paddle_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, up_db, down_db, game_en, recenter;
  logic [9:0] pos, pos2;
  logic       at_top, at_bot, moving;
  logic       at_top2, at_bot2, moving2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  paddle_ctrl u_dut (
    .clk(clk), .rst(rst), .tick(tick), .up_db(up_db), .down_db(down_db),
    .game_en(game_en), .recenter(recenter),
    .pos(pos), .at_top(at_top), .at_bot(at_bot), .moving(moving)
  );

  paddle_ctrl #(.POS_RST(2)) u_dut2 (
    .clk(clk), .rst(rst), .tick(tick), .up_db(up_db), .down_db(down_db),
    .game_en(game_en), .recenter(recenter),
    .pos(pos2), .at_top(at_top2), .at_bot(at_bot2), .moving(moving2)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // Each tick is a one-clk strobe followed by one quiet clk.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      clk1();
      tick = 1'b0;
      clk1();
    end
  endtask

  task automatic do_recenter();
    recenter = 1'b1;
    clk1();
    recenter = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; up_db = 1'b0; down_db = 1'b0;
    game_en = 1'b1; recenter = 1'b0;
    repeat (3) clk1();
    check("rst_pos", pos, 200);
    rst = 1'b0;
    repeat (100) clk1();
    check("idle_pos", pos, 200);
    check("idle_top", at_top, 0);
    check("idle_bot", at_bot, 0);
    check("idle_moving", moving, 0);

    // Single press up, then release.
    up_db = 1'b1;
    clk1();
    check("press_up_pos", pos, 196);
    check("press_up_moving", moving, 1);
    up_db = 1'b0;
    clk1();
    check("release_moving", moving, 0);
    ticks(10);
    check("release_pos", pos, 196);

    // Recenter.
    do_recenter();
    check("recenter_pos", pos, 200);
    check("recenter_moving", moving, 0);
    check("recenter_pos2", pos2, 2);

    // Hold down: press, delay, repeat, accelerate.
    down_db = 1'b1;
    clk1();
    check("dn_press", pos, 204);
    ticks(7);
    check("dn_delay7", pos, 204);
    check("dn_delay_moving", moving, 1);
    ticks(1);
    check("dn_delay8", pos, 208);
    ticks(31);
    check("dn_rep15", pos, 268);
    ticks(1);
    check("dn_rep16", pos, 272);
    ticks(2);
    check("dn_fast1", pos, 280);
    ticks(2);
    check("dn_fast2", pos, 288);

    // Disable freezes; re-enable while still held gives no press edge.
    game_en = 1'b0;
    clk1();
    check("dis_moving", moving, 0);
    ticks(4);
    check("dis_pos", pos, 288);
    game_en = 1'b1;
    ticks(4);
    check("reen_pos", pos, 288);

    // Bottom clamp.
    down_db = 1'b0;
    clk1();
    down_db = 1'b1;
    clk1();
    check("bot_press", pos, 292);
    ticks(8);
    check("bot_delay", pos, 296);
    ticks(32);
    check("bot_rep16", pos, 360);
    ticks(8);
    check("bot_392", pos, 392);
    check("bot_392_flag", at_bot, 0);
    ticks(2);
    check("bot_400", pos, 400);
    check("bot_400_flag", at_bot, 1);
    ticks(4);
    check("bot_sat_pos", pos, 400);
    check("bot_sat_flag", at_bot, 1);
    check("bot_sat_moving", moving, 1);

    // Top clamp on the second instance.
    down_db = 1'b0;
    clk1();
    do_recenter();
    check("top_pre_pos2", pos2, 2);
    check("top_pre_pos", pos, 200);
    up_db = 1'b1;
    clk1();
    check("top_clamp_pos2", pos2, 0);
    check("top_clamp_flag2", at_top2, 1);
    check("top_clamp_pos", pos, 196);
    ticks(4);
    check("top_sat_pos2", pos2, 0);
    check("top_sat_moving2", moving2, 1);
    check("top_sat_flag2", at_top2, 1);

    // Both buttons during REPEAT.
    up_db = 1'b0;
    clk1();
    do_recenter();
    down_db = 1'b1;
    clk1();
    check("both_press", pos, 204);
    ticks(8);
    ticks(2);
    check("both_rep1", pos, 212);
    up_db = 1'b1;
    clk1();
    check("both_moving", moving, 0);
    ticks(4);
    check("both_pos", pos, 212);
    up_db = 1'b0;
    clk1();
    check("both_drop_pos", pos, 216);
    check("both_drop_moving", moving, 1);

    // Asynchronous reset mid-REPEAT.
    ticks(8);
    ticks(2);
    check("pre_rst_pos", pos, 224);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_pos", pos, 200);
    check("async_rst_moving", moving, 0);
    down_db = 1'b0;
    clk1();
    clk1();
    rst = 1'b0;
    clk1();
    check("post_rst_pos", pos, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
